ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the banked RAM (1 write port, 2 async read ports A/B, 16-bit data) among NREQ requesters.
//  Each cycle grants at most one write and at most two reads, with round-robin fairness.
//  Returns read data, or a write acknowledge, on a registered per-requester response channel.
//  Sits between client engines and the RAM; it is the only driver of the RAM's port signals.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  AW    33  address width; matches the RAM wr_addr/rd_addr_*
//  DW    16  data width; matches the RAM d_in/d_out_*
// PORTS
//  clk        in   1         single clock; all state on posedge
//  reset      in   1         asynchronous, active-low reset
//  req_valid  in   NREQ      request valid, one bit per requester
//  req_we     in   NREQ      1 = write, 0 = read
//  req_addr   in   NREQ*AW   request address, packed [i*AW +: AW]
//  req_wdata  in   NREQ*DW   write data, packed [i*DW +: DW]
//  req_ready  out  NREQ      combinational grant; transfer occurs when valid & ready
//  rsp_valid  out  NREQ      registered 1-cycle response pulse
//  rsp_rdata  out  NREQ*DW   registered read data; 0 for write acks
//  wr         out  1         RAM write enable
//  wr_addr    out  AW        RAM write address
//  d_in       out  DW        RAM write data
//  rd_addr_a  out  AW        RAM read address, port A
//  rd_addr_b  out  AW        RAM read address, port B
//  d_out_a    in   DW        RAM read data A (combinational from rd_addr_a)
//  d_out_b    in   DW        RAM read data B
// BEHAVIOUR
//  - Reset (reset=0): wr_ptr=rd_ptr=0, rsp_valid=0, rsp_rdata=0. req_ready=0 and wr=0 while in reset.
//    rd_addr_a/b, wr_addr and d_in are 0 while idle. Responses in flight at reset assertion are dropped.
//  - Write arbitration: among i with valid&we, grant the first found scanning from wr_ptr upward
//    (mod NREQ). On a grant to k: wr=1, wr_addr/d_in = requester k payload, wr_ptr <= (k+1)%NREQ.
//  - Read arbitration: among i with valid&!we, grant the first two found scanning from rd_ptr.
//    The 1st grant drives port A, the 2nd drives port B. rd_ptr <= (last granted + 1)%NREQ.
//    With no grant, a pointer holds its value.
//  - A requester issues one op per cycle, so it can never receive both a read and a write grant.
//  - req_ready[i]=1 only in the grant cycle. Requesters must hold valid and payload stable until ready.
//    Deasserting valid before a grant is legal; the request is simply withdrawn.
//  - Latency: exactly 1 cycle. rsp_valid[i] pulses on the cycle after the accept.
//    For a read, rsp_rdata[i] = d_out_a or d_out_b, sampled at the accept edge.
//    For a write, rsp_rdata[i] = 0.
//  - Ungranted requesters get rsp_valid=0, and their rsp_rdata holds its last value.
//  - Same-cycle write and read to the same address: the read returns the OLD contents
//    (read is sampled before the write edge). The write is visible to reads accepted on later cycles.
//  - Back-to-back accepts are allowed; a requester may be granted every cycle if it is the only contender.
//  - Pointer wrap: NREQ-1 + 1 -> 0. Bound: with all requesters continuously requesting,
//    any requester waits at most NREQ-1 cycles (writes) or ceil((NREQ-1)/2) cycles (reads).
//  - Addresses pass through unchanged. Bank select by the upper address bit is the RAM's job.
// STRUCTURE
//  - Shared package ram_pkg: localparams RAM_AW=33, RAM_DW=16; function clog2 for pointer width.
//  - Sub-module rr_pick #(N): inputs req vector and ptr; outputs one-hot of the first set bit
//    at or after ptr (rotate, priority-encode, rotate back).
//    Used once for the write grant and twice for the reads (2nd pick uses req & ~first).
//  - Top: two pointer registers, payload muxes, response registers.
// TESTING
//  1 Reset: hold reset=0 with all valid=1 -> req_ready=0, wr=0, rsp_valid=0.
//    Release reset -> requester 0 is granted first.
//  2 Single write then read: req0 writes 0xABCD @0. Next cycle rsp_valid[0]=1, rsp_rdata=0.
//    req0 reads @0 -> the cycle after the accept, rsp_rdata[0]=0xABCD.
//  3 Dual read: req1 reads @0 and req2 reads @1 (pre-written 0xABCD, 0x1234) in the same cycle.
//    Both are granted, via A and B. Next cycle: rsp1=0xABCD, rsp2=0x1234.
//  4 Write fairness: all 4 write continuously. Grants go 0,1,2,3,0.
//    Bank select: write @33'h1_0000_0000=0x5678, then read it back -> 0x5678.
//  5 Hazard: req0 writes 0x1111 @5 (old 0x2222) while req1 reads @5 in the same cycle -> rsp1=0x2222.
//    Re-read @5 on the next cycle -> 0x1111.
//  6 Reset mid-op: assert reset in the cycle after an accept -> rsp_valid stays 0 and the pointers return to 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared RAM geometry and helpers for the RAM port arbiter and its sub-blocks.
package ram_pkg;

    localparam int RAM_AW = 33;
    localparam int RAM_DW = 16;

    // Minimum bit width to hold values 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot of the first set request bit at or after ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign rot   = N'({req, req} >> ptr);
    assign first = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    assign gnt   = N'(({first, first} << ptr) >> N);

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NREQ requesters onto one RAM write port and two async read ports,
// returning registered per-requester responses one cycle after each accept.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic               wr,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      d_in,
    output logic [AW-1:0]      rd_addr_a,
    output logic [AW-1:0]      rd_addr_b,
    input  logic [DW-1:0]      d_out_a,
    input  logic [DW-1:0]      d_out_b
);

    localparam int PW = clog2(NREQ);

    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [NREQ-1:0]    wr_cand, rd_cand;
    logic [NREQ-1:0]    wr_gnt, rd_gnt_a, rd_gnt_b;
    logic [NREQ-1:0]    rsp_valid_reg;
    logic [NREQ*DW-1:0] rsp_rdata_reg;

    // Candidates are masked while in reset so no grant can leak out.
    assign wr_cand = reset ? (req_valid & req_we)  : '0;
    assign rd_cand = reset ? (req_valid & ~req_we) : '0;

    rr_pick #(.N(NREQ), .PW(PW)) u_wr_pick (
        .req (wr_cand),
        .ptr (wr_ptr_reg),
        .gnt (wr_gnt)
    );

    rr_pick #(.N(NREQ), .PW(PW)) u_rd_pick_a (
        .req (rd_cand),
        .ptr (rd_ptr_reg),
        .gnt (rd_gnt_a)
    );

    rr_pick #(.N(NREQ), .PW(PW)) u_rd_pick_b (
        .req (rd_cand & ~rd_gnt_a),
        .ptr (rd_ptr_reg),
        .gnt (rd_gnt_b)
    );

    assign req_ready = wr_gnt | rd_gnt_a | rd_gnt_b;

    always_comb begin
        wr          = 1'b0;
        wr_addr     = '0;
        d_in        = '0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        for (int i = 0; i < NREQ; i++) begin
            if (wr_gnt[i]) begin
                wr          = 1'b1;
                wr_addr     = req_addr[i*AW +: AW];
                d_in        = req_wdata[i*DW +: DW];
                wr_ptr_next = PW'((i + 1) % NREQ);
            end
            // The read pointer advances past the last read granted this cycle.
            if (rd_gnt_a[i]) begin
                rd_addr_a = req_addr[i*AW +: AW];
                if (~|rd_gnt_b) begin
                    rd_ptr_next = PW'((i + 1) % NREQ);
                end
            end
            if (rd_gnt_b[i]) begin
                rd_addr_b   = req_addr[i*AW +: AW];
                rd_ptr_next = PW'((i + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Read data is captured at the accept edge, so a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (rd_gnt_a[i]) begin
                    rsp_rdata_reg[i*DW +: DW] <= d_out_a;
                end else if (rd_gnt_b[i]) begin
                    rsp_rdata_reg[i*DW +: DW] <= d_out_b;
                end else if (wr_gnt[i]) begin
                    rsp_rdata_reg[i*DW +: DW] <= '0;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: stimulus pushes expected responses into a
// scoreboard queue that a negedge monitor drains whenever rsp_valid is seen.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 33;
    localparam int DW = 16;

    localparam logic [N*AW-1:0] A_ALL  = {33'h1_0000_0000, 33'd5, 33'd1, 33'd0};
    localparam logic [N*DW-1:0] D_ALL  = {16'h5678, 16'h2222, 16'h1234, 16'hABCD};
    localparam logic [N*DW-1:0] ED_ALL = {16'h5678, 16'h1111, 16'h1234, 16'hABCD};

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_rdata;
    logic            wr;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   d_in;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [DW-1:0]   d_out_a;
    logic [DW-1:0]   d_out_b;

    logic [DW-1:0] mem [64];
    exp_t          sb_q [$];
    int            errors = 0;
    int            checks = 0;

    ram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RAM model: bank bit plus low address bits, async read, posedge write.
    function automatic int midx(input logic [AW-1:0] a);
        return int'({a[32], a[4:0]});
    endfunction

    assign d_out_a = mem[midx(rd_addr_a)];
    assign d_out_b = mem[midx(rd_addr_b)];

    always @(posedge clk) begin
        if (wr) mem[midx(wr_addr)] <= d_in;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: requester %0d rsp_valid=1 with nothing expected", i);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("rsp_idx(req%0d)", i), 64'(i), 64'(e.idx));
                    check($sformatf("rsp_data(req%0d)", i), 64'(rsp_rdata[i*DW +: DW]), 64'(e.data));
                end
            end
        end
    end

    // Drive one cycle of requests (called just after a negedge), check the grant, queue responses.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] w,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                        input logic [N-1:0] er, input logic [N*DW-1:0] ed);
        req_valid = v;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        check("req_ready", 64'(req_ready), 64'(er));
        $display("step valid=%b we=%b ready=%b (want %b)", v, w, req_ready, er);
        for (int i = 0; i < N; i++) begin
            if (er[i]) begin
                exp_t e;
                e.idx  = i;
                e.data = ed[i*DW +: DW];
                sb_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset     = 1'b0;
        req_valid = '1;
        req_we    = '1;
        req_addr  = A_ALL;
        req_wdata = D_ALL;

        // Reset held with every requester asking.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_ready", 64'(req_ready), 64'h0);
            check("reset_wr", 64'(wr), 64'h0);
            check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
            check("reset_rsp_rdata", 64'(rsp_rdata), 64'h0);
        end
        reset = 1'b1;

        // Continuous writes from all: grants 0,1,2,3,0.
        step(4'hF, 4'hF, A_ALL, D_ALL, 4'b0001, '0);
        step(4'hF, 4'hF, A_ALL, D_ALL, 4'b0010, '0);
        step(4'hF, 4'hF, A_ALL, D_ALL, 4'b0100, '0);
        step(4'hF, 4'hF, A_ALL, D_ALL, 4'b1000, '0);
        step(4'hF, 4'hF, A_ALL, D_ALL, 4'b0001, '0);
        // Single read, dual read via A/B, bank-1 read.
        step(4'b0001, 4'b0000, A_ALL, '0, 4'b0001, {48'h0, 16'hABCD});
        step(4'b0110, 4'b0000, {33'd0, 33'd1, 33'd0, 33'd0}, '0, 4'b0110,
             {16'h0, 16'h1234, 16'hABCD, 16'h0});
        step(4'b1000, 4'b0000, A_ALL, '0, 4'b1000, {16'h5678, 48'h0});
        // Same-cycle write and read of address 5, then re-read.
        step(4'b0011, 4'b0001, {33'd0, 33'd0, 33'd5, 33'd5}, {48'h0, 16'h1111}, 4'b0011,
             {32'h0, 16'h2222, 16'h0});
        step(4'b0010, 4'b0000, {33'd0, 33'd0, 33'd5, 33'd0}, '0, 4'b0010,
             {32'h0, 16'h1111, 16'h0});
        // Read fairness with all reading: 2,3 then 0,1.
        step(4'hF, 4'h0, A_ALL, '0, 4'b1100, ED_ALL);
        step(4'hF, 4'h0, A_ALL, '0, 4'b0011, ED_ALL);
        // Mixed write/read contention.
        step(4'hF, 4'b0101, {33'd0, 33'd8, 33'd1, 33'd7}, {16'h0, 16'h8888, 16'h0, 16'h7777},
             4'b1110, {16'hABCD, 16'h0, 16'h1234, 16'h0});
        step(4'b0011, 4'b0001, {33'd0, 33'd0, 33'd8, 33'd7}, {48'h0, 16'h7777}, 4'b0011,
             {32'h0, 16'h8888, 16'h0});
        // Idle: nothing granted, RAM ports parked, read data held.
        step(4'h0, 4'h0, '0, '0, 4'b0000, '0);
        #1;
        check("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        check("idle_rdata_hold", 64'(rsp_rdata[1*DW +: DW]), 64'h8888);
        check("idle_wr", 64'(wr), 64'h0);
        check("idle_rd_addr_a", 64'(rd_addr_a), 64'h0);
        check("idle_rd_addr_b", 64'(rd_addr_b), 64'h0);

        // Reset asserted right after an accept: response dropped, pointers cleared.
        req_valid = 4'b0100;
        req_we    = 4'b0100;
        req_addr  = {33'd0, 33'd9, 33'd0, 33'd0};
        req_wdata = {16'h0, 16'h9999, 32'h0};
        #1;
        check("midop_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("midop_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midop_rsp_rdata", 64'(rsp_rdata), 64'h0);
        check("midop_ready_in_reset", 64'(req_ready), 64'h0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        step(4'hF, 4'hF, {99'h0, 33'd20}, {48'h0, 16'h2020}, 4'b0001, '0);
        step(4'hF, 4'h0, A_ALL, '0, 4'b0011, ED_ALL);
        step(4'h0, 4'h0, '0, '0, 4'b0000, '0);
        step(4'h0, 4'h0, '0, '0, 4'b0000, '0);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
